// File: rtl/pio_seq_pkg.sv
// rtl/pio_seq_pkg.sv - shared types, SEQCTL bit map and DMD pattern pack/unpack for pio_seq
package pio_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DELAY = 2'd2
  } seq_state_e;

  localparam int IDX_W = 2;

  localparam int CTL_EN       = 0;
  localparam int CTL_LOOP     = 1;
  localparam int CTL_LAST_LO  = 2;
  localparam int CTL_IE       = 4;
  localparam int CTL_DONE     = 5;
  localparam int CTL_BUSY     = 6;
  localparam int CTL_IDX_LO   = 8;
  localparam int CTL_STALL_LO = 10;

  // 12-bit flag patterns live in DMD as {DMD[15:12], DMD[7:0]}
  function automatic logic [11:0] dmd_to_pat(input logic [15:0] d);
    return {d[15:12], d[7:0]};
  endfunction

  function automatic logic [15:0] pat_to_dmd(input logic [11:0] p);
    return {p[11:8], 4'b0000, p[7:0]};
  endfunction

endpackage

// File: rtl/pio_seq_tbl.sv
// rtl/pio_seq_tbl.sv - DEPTH x 12 pattern register file, one write port, async read port
module pio_seq_tbl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          PIOCLK5,
  input  logic          T_RST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [11:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [11:0]   rdata
);

  logic [11:0] mem [DEPTH];

  always_ff @(posedge PIOCLK5 or posedge T_RST) begin
    if (T_RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pio_seq.sv
// rtl/pio_seq.sv - PFDATA pattern sequencer; optional stall counter under PIO_SEQ_STALLCNT_EN
module pio_seq
  import pio_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DLY_W = 16
) (
  input  logic        PIOCLK5,
  input  logic        T_RST,
  input  logic [15:0] DMD,
  input  logic        SEQCTL_we,
  input  logic        SEQDLY_we,
  input  logic        SEQPAT_we,
  input  logic [1:0]  SEQPAT_ADDR,
  input  logic        selSEQCTL,
  input  logic        selSEQDLY,
  input  logic        CPU_PFDATA_we,
  output logic        SEQ_PFDATA_we,
  output logic [15:0] SEQ_DMD_W,
  output logic        SEQ_busy,
  output logic        SEQ_INTn,
  output logic [15:0] SEQ_RD
);

  seq_state_e       state;
  logic             en, loop_m, ie, done;
  logic [IDX_W-1:0] last, idx;
  logic [DLY_W-1:0] dly, cnt;
  logic [11:0]      tbl_rd;
  logic [5:0]       stall;
  logic             issue_ok;

  // CPU writes and control rewrites both pre-empt the sequencer's slot
  assign issue_ok      = (state == S_ISSUE) & ~CPU_PFDATA_we & ~SEQCTL_we;
  assign SEQ_PFDATA_we = issue_ok;

  pio_seq_tbl #(.DEPTH(DEPTH), .AW(IDX_W)) u_tbl (
    .PIOCLK5 (PIOCLK5),
    .T_RST   (T_RST),
    .we      (SEQPAT_we),
    .waddr   (SEQPAT_ADDR),
    .wdata   (dmd_to_pat(DMD)),
    .raddr   (idx),
    .rdata   (tbl_rd)
  );

  always_ff @(posedge PIOCLK5 or posedge T_RST) begin
    if (T_RST) begin
      state  <= S_IDLE;
      en     <= 1'b0;
      loop_m <= 1'b0;
      ie     <= 1'b0;
      done   <= 1'b0;
      last   <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else if (SEQCTL_we) begin
      done   <= 1'b0;
      en     <= DMD[CTL_EN];
      loop_m <= DMD[CTL_LOOP];
      last   <= DMD[CTL_LAST_LO +: IDX_W];
      ie     <= DMD[CTL_IE];
      if (DMD[CTL_EN]) begin
        idx   <= '0;
        state <= S_ISSUE;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_ISSUE: begin
          if (issue_ok) begin
            if (idx == last && !loop_m) begin
              state <= S_IDLE;
              done  <= 1'b1;
              en    <= 1'b0;
            end else begin
              idx <= (idx == last) ? '0 : idx + 1'b1;
              if (dly == '0) begin
                state <= S_ISSUE;
              end else begin
                state <= S_DELAY;
                cnt   <= dly - 1'b1;
              end
            end
          end
        end
        S_DELAY: begin
          if (cnt == '0) state <= S_ISSUE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PIOCLK5 or posedge T_RST) begin
    if (T_RST)          dly <= '0;
    else if (SEQDLY_we) dly <= DMD[DLY_W-1:0];
  end

`ifdef PIO_SEQ_STALLCNT_EN
  always_ff @(posedge PIOCLK5 or posedge T_RST) begin
    if (T_RST)                                              stall <= '0;
    else if (SEQCTL_we)                                     stall <= '0;
    else if (state == S_ISSUE && !issue_ok && stall != 6'd63) stall <= stall + 6'd1;
  end
`else
  assign stall = '0;
`endif

  logic [15:0] ctl_rd;
  logic [15:0] dly_rd;

  assign SEQ_busy  = (state != S_IDLE);
  assign SEQ_INTn  = ~(done & ie);
  assign SEQ_DMD_W = pat_to_dmd(tbl_rd);
  assign ctl_rd    = {stall, idx, 1'b0, SEQ_busy, done, ie, last, loop_m, en};
  assign dly_rd    = 16'(dly);
  assign SEQ_RD    = ({16{selSEQCTL}} & ctl_rd) | ({16{selSEQDLY}} & dly_rd);

endmodule

// File: doc/pio_seq.md
# pio_seq

Autonomous output-pattern sequencer for the programmable flag (PIO) block. It holds a small table of 12-bit flag patterns and writes them one at a time into PFDATA at a programmed inter-step delay, in one-shot or loop mode. It shares the PFDATA write port with the CPU; CPU writes always win. It sits beside the PIO block in the PIOCLK5 domain, and its write-data/strobe outputs are muxed into the PFDATA write path.

## Interface
Parameters:
- DEPTH, 4, pattern table entries (index width 2)
- DLY_W, 16, delay counter width

Ports:
- PIOCLK5  in  1  clock (gated PIO clock, flags 10/11 group)
- T_RST  in  1  reset, asynchronous, active-high
- DMD  in  16  MMR write data; 12-bit fields taken as {DMD[15:12],DMD[7:0]}
- SEQCTL_we  in  1  write SEQCTL from DMD
- SEQDLY_we  in  1  write SEQDLY from DMD[15:0]
- SEQPAT_we  in  1  write table entry SEQPAT_ADDR
- SEQPAT_ADDR  in  2  table entry index
- selSEQCTL, selSEQDLY  in  1 each  readback selects
- CPU_PFDATA_we  in  1  CPU writes PFDATA this cycle (blocks sequencer)
- SEQ_PFDATA_we  out  1  sequencer PFDATA write strobe
- SEQ_DMD_W  out  16  write data, DMD layout {p[11:8],4'b0,p[7:0]}
- SEQ_busy  out  1  FSM not IDLE
- SEQ_INTn  out  1  active-low done interrupt
- SEQ_RD  out  16  readback, OR of selected registers

## Operation
- SEQCTL: [0] EN, [1] LOOP, [3:2] LAST (final index), [4] IE, [5] DONE (RO), [6] BUSY (RO), [9:8] IDX (RO), [15:10] STALL (RO, see Configuration).
- SEQDLY: D = idle cycles between steps.
- FSM states: IDLE, ISSUE, DELAY.
- Any SEQCTL write clears DONE. EN=1 sets IDX=0 and enters ISSUE from any state (restart). EN=0 enters IDLE (abort).
- ISSUE: SEQ_PFDATA_we = !CPU_PFDATA_we & !SEQCTL_we. If blocked, hold ISSUE and hold IDX.
- After a write:
  - IDX==LAST & !LOOP: go IDLE, set DONE, clear EN.
  - IDX==LAST & LOOP: IDX wraps to 0.
  - Otherwise: IDX+1.
  - Next state is DELAY with counter=D-1, or ISSUE directly if D==0.
- DELAY: count down; at 0 go ISSUE.
- SEQ_DMD_W = table[IDX] in all states.
- A table write to the active IDX during DELAY takes effect at the next ISSUE. A table write in the same cycle as its ISSUE outputs the old value.
- SEQDLY written mid-DELAY applies from the next reload.
- SEQ_INTn = !(DONE & IE).

## Timing
- Reset values: SEQ_PFDATA_we=0, SEQ_DMD_W=0, SEQ_busy=0, SEQ_INTn=1, SEQ_RD=0. All registers, table, IDX and counter are 0; state is IDLE.
- SEQCTL EN write at edge N: first SEQ_PFDATA_we in cycle N+1.
- Unstalled write-to-write spacing: D+1 cycles.
- SEQ_PFDATA_we and SEQ_RD are combinational from state/registers/selects; all other outputs are registered.
- DONE and BUSY=0 are visible in the cycle after the last write.
- Reset mid-operation: immediate return to IDLE, no write issued.

## Configuration
- PIO_SEQ_STALLCNT_EN defined: 6-bit saturating counter of cycles spent blocked in ISSUE, readable in SEQCTL[15:10]. Cleared by any SEQCTL write. Holds at 63.
- Not defined: SEQCTL[15:10] reads 0 and no counter is built.

## Structure
- Shared package `pio_seq_pkg`: state enum, SEQCTL bit positions, DMD-to-12-bit pack/unpack helpers.
- Sub-module `pio_seq_tbl`: DEPTH x 12 register file with one write port and one async read port indexed by IDX; reset to 0.

## Test plan
- Reset: assert T_RST mid-DELAY -> SEQ_busy=0, SEQ_INTn=1, no further SEQ_PFDATA_we; SEQ_RD reads 0 for both selects.
- One-shot: table 0x001/0x002/0x004/0x008, LAST=3, D=2, EN written at edge N -> writes in cycles N+1, N+4, N+7, N+10 with SEQ_DMD_W 0x0001/0x0002/0x0004/0x0008; DONE=1 and BUSY=0 at N+11.
- Arbitration: CPU_PFDATA_we high for 3 cycles covering the second ISSUE -> second write slips 3 cycles, later spacing stays 3; with the macro, STALL=3.
- Loop: LAST=1, D=0, LOOP=1, table A=0xA5A, B=0x5A5 -> SEQ_DMD_W alternates 0xA05A/0x50A5 on consecutive writes; SEQCTL EN=0 write -> no strobe in the write cycle or afterwards.
- Interrupt: IE=1, one-shot completes -> SEQ_INTn=0; next SEQCTL write -> SEQ_INTn=1 the following cycle.
- Live table update: rewrite entry 2 during DELAY before step 2 -> new value is issued at step 2.
